// File: rtl/btu_pkg.sv
// rtl/btu_pkg.sv - shared types, constants and helpers for the bit-transpose unit
package btu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_WORDS  = 32;
    localparam int MAX_N      = 16;
    localparam int MAX_OUTPUT = 32;
    localparam int MIN_N      = 1;

    localparam int N_W        = 5;
    localparam int WCNT_W     = $clog2(NUM_WORDS);
    localparam int RCNT_W     = $clog2(MAX_OUTPUT);
    // One extra bit so that out-of-range row counts from the core stay visible
    localparam int ROWS_W     = $clog2(MAX_OUTPUT) + 1;

    typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  btu_words_t;
    typedef logic [MAX_OUTPUT-1:0][DATA_WIDTH-1:0] btu_rows_t;

    typedef struct packed {
        logic [N_W-1:0] n;
        btu_words_t     data;
    } btu_input_t;

    typedef struct packed {
        logic [ROWS_W-1:0] num_rows;
        btu_rows_t         rows;
    } btu_output_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } btu_sched_state_e;

    // Bit width the core can transpose
    function automatic logic n_legal(input logic [N_W-1:0] n);
        return (n >= N_W'(MIN_N)) && (n <= N_W'(MAX_N));
    endfunction

    // Row count the controller can stream out
    function automatic logic rows_legal(input logic [ROWS_W-1:0] num_rows);
        return (num_rows != '0) && (num_rows <= ROWS_W'(MAX_OUTPUT));
    endfunction

endpackage

// File: rtl/btu_sched.sv
// rtl/btu_sched.sv - job sequencer: load words, issue to core, drain rows
module btu_sched
    import btu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [N_W-1:0]        cfg_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,

    output logic                  core_req_valid,
    input  logic                  core_req_ready,
    output btu_input_t            core_req,

    input  logic                  core_rsp_valid,
    output logic                  core_rsp_ready,
    input  btu_output_t           core_rsp,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RCNT_W-1:0]     out_idx,
    output logic                  out_last,

    output logic                  busy,
    output logic                  err
);

    localparam int              WD_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    btu_sched_state_e     state;
    btu_sched_state_e     state_next;

    logic [N_W-1:0]       n_q;
    logic [WCNT_W-1:0]    wcnt;
    logic [WD_W-1:0]      wd;
    logic [RCNT_W-1:0]    rcnt;
    logic [ROWS_W-1:0]    num_rows_q;
    btu_words_t           word_buf;
    btu_rows_t            rows_q;
    logic                 err_q;

    logic                 cfg_fire;
    logic                 in_fire;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 out_fire;
    logic                 last_word;
    logic                 last_row;
    logic                 timeout_hit;
    logic                 rsp_ok;

    // Handshake qualifiers; every ready/valid from this side is a state decode
    always_comb begin
        cfg_fire    = cfg_valid && cfg_ready;
        in_fire     = in_valid && in_ready;
        req_fire    = core_req_valid && core_req_ready;
        rsp_fire    = core_rsp_valid && core_rsp_ready;
        out_fire    = out_valid && out_ready;
        last_word   = (wcnt == WCNT_W'(NUM_WORDS - 1));
        last_row    = ({1'b0, rcnt} == (num_rows_q - ROWS_W'(1)));
        timeout_hit = TIMEOUT_EN && (wd == WD_LAST);
        rsp_ok      = rows_legal(core_rsp.num_rows);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a response in the last watchdog cycle beats the timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cfg_fire && n_legal(cfg_n)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (in_fire && last_word) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rsp_fire) begin
                    state_next = rsp_ok ? DRAIN : IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (out_fire && last_row) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from registered state, counters and captured data
    always_comb begin
        cfg_ready      = 1'b0;
        in_ready       = 1'b0;
        core_req_valid = 1'b0;
        core_rsp_ready = 1'b0;
        out_valid      = 1'b0;
        case (state)
            IDLE:    cfg_ready      = 1'b1;
            LOAD:    in_ready       = 1'b1;
            ISSUE:   core_req_valid = 1'b1;
            WAIT:    core_rsp_ready = 1'b1;
            DRAIN:   out_valid      = 1'b1;
            default: cfg_ready      = 1'b0;
        endcase
        core_req.n    = n_q;
        core_req.data = word_buf;
        out_data      = rows_q[rcnt];
        out_idx       = rcnt;
        out_last      = (state == DRAIN) && last_row;
        busy          = (state != IDLE);
        err           = err_q;
    end

    // Job datapath: word staging, watchdog, response capture, row counter
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q        <= '0;
            wcnt       <= '0;
            wd         <= '0;
            rcnt       <= '0;
            num_rows_q <= '0;
            word_buf   <= '0;
            rows_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        if (n_legal(cfg_n)) begin
                            n_q  <= cfg_n;
                            wcnt <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        word_buf[wcnt] <= in_data;
                        wcnt           <= wcnt + WCNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (req_fire) begin
                        wd <= '0;
                    end
                end
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    if (rsp_fire) begin
                        rows_q     <= core_rsp.rows;
                        num_rows_q <= core_rsp.num_rows;
                        rcnt       <= '0;
                        if (!rsp_ok) begin
                            err_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        rcnt <= rcnt + RCNT_W'(1);
                    end
                end
                default: begin
                    err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btu_sched.sv
// tb/tb_btu_sched.sv - randomized self-checking bench for btu_sched
module tb_btu_sched;
    import btu_pkg::*;

    localparam int TMO = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [N_W-1:0]        cfg_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  core_req_valid;
    logic                  core_req_ready;
    btu_input_t            core_req;
    logic                  core_rsp_valid;
    logic                  core_rsp_ready;
    btu_output_t           core_rsp;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RCNT_W-1:0]     out_idx;
    logic                  out_last;
    logic                  busy;
    logic                  err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    btu_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_n(cfg_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req(core_req),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready), .core_rsp(core_rsp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench stalled");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        cfg_valid      = 1'b0;
        cfg_n          = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        core_req_ready = 1'b0;
        core_rsp_valid = 1'b0;
        core_rsp       = '0;
        out_ready      = 1'b0;
    endtask

    // Pulse reset mid-job; the controller must be idle right after and stay silent
    task automatic mid_reset(input string tag);
        int quiet_bad;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0)
            begin failures++; $display("FAIL %s_idle busy=%0b cfg_ready=%0b out_valid=%0b in_ready=%0b err=%0b exp 0/1/0/0/0", tag, busy, cfg_ready, out_valid, in_ready, err); end
        quiet_bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) quiet_bad++;
        end
        checks++;
        if (quiet_bad != 0) begin failures++; $display("FAIL %s_quiet bad_cycles=%0d exp 0", tag, quiet_bad); end
    endtask

    // One whole job against the reference: words in order, rows out in order.
    // rsp_dly < 0 means the core never answers.
    task automatic run_job(input logic [N_W-1:0] n, input int nr, input bit seq_words,
                           input int in_pct, input int req_dly, input int rsp_dly,
                           input int stall_row, input int stall_len,
                           input int abort_word, input int abort_row);
        logic [DATA_WIDTH-1:0] w [NUM_WORDS];
        logic [DATA_WIDTH-1:0] r [MAX_OUTPUT];
        btu_input_t snap;
        int k, j, guard, e_cfg, bad, stalled, first_bad, exp_lat;
        logic [DATA_WIDTH-1:0] got_d;
        for (int i = 0; i < NUM_WORDS; i++) w[i] = seq_words ? 32'(i) : $urandom;
        for (int i = 0; i < MAX_OUTPUT; i++) r[i] = $urandom;

        checks++;
        if (cfg_ready !== 1'b1) begin failures++; $display("FAIL job_cfg_ready got=%0b exp=1", cfg_ready); end
        cfg_valid = 1'b1;
        cfg_n     = n;
        step();
        cfg_valid = 1'b0;
        e_cfg     = cyc;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || cfg_ready !== 1'b0)
            begin failures++; $display("FAIL job_load_entry busy=%0b in_ready=%0b cfg_ready=%0b exp 1/1/0", busy, in_ready, cfg_ready); end

        k = 0;
        guard = 0;
        while (k < NUM_WORDS && guard < 2000) begin
            if (k == abort_word) begin mid_reset("rst_load"); return; end
            in_valid = ($urandom_range(99) < in_pct);
            in_data  = w[k];
            if (in_valid && in_ready) k++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (k != NUM_WORDS || in_ready !== 1'b0 || core_req_valid !== 1'b1)
            begin failures++; $display("FAIL load_done words=%0d in_ready=%0b req_valid=%0b exp %0d/0/1", k, in_ready, core_req_valid, NUM_WORDS); end

        snap = core_req;
        bad = 0;
        for (int i = 0; i < req_dly; i++) begin
            step();
            if (core_req_valid !== 1'b1 || core_req !== snap || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL req_hold unstable_cycles=%0d exp 0", bad); end
        checks++;
        if (snap.n !== n) begin failures++; $display("FAIL req_n got=%0d exp=%0d", snap.n, n); end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < NUM_WORDS; i++)
            if (snap.data[i] !== w[i]) begin bad++; if (first_bad < 0) first_bad = i; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL req_data bad_words=%0d first=%0d got=%h exp=%h", bad, first_bad, snap.data[first_bad], w[first_bad]); end

        core_req_ready = 1'b1;
        step();
        core_req_ready = 1'b0;
        checks++;
        if (core_rsp_ready !== 1'b1 || core_req_valid !== 1'b0)
            begin failures++; $display("FAIL wait_entry rsp_ready=%0b req_valid=%0b exp 1/0", core_rsp_ready, core_req_valid); end

        if (rsp_dly < 0) begin
            bad = 0;
            for (int i = 0; i < TMO; i++) begin
                if (core_rsp_ready !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0) bad++;
                step();
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL tmo_wait bad_cycles=%0d exp 0", bad); end
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
                begin failures++; $display("FAIL tmo_err err=%0b busy=%0b out_valid=%0b exp 1/0/0", err, busy, out_valid); end
            step();
            checks++;
            if (err !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL tmo_pulse err=%0b cfg_ready=%0b exp 0/1", err, cfg_ready); end
            return;
        end

        for (int i = 0; i < rsp_dly; i++) step();
        core_rsp_valid    = 1'b1;
        core_rsp.num_rows = ROWS_W'(nr);
        for (int i = 0; i < MAX_OUTPUT; i++) core_rsp.rows[i] = r[i];
        step();
        core_rsp_valid = 1'b0;

        if (nr < 1 || nr > MAX_OUTPUT) begin
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
                begin failures++; $display("FAIL rows_err nr=%0d err=%0b busy=%0b out_valid=%0b exp 1/0/0", nr, err, busy, out_valid); end
            step();
            checks++;
            if (err !== 1'b0) begin failures++; $display("FAIL rows_pulse err=%0b exp=0", err); end
            return;
        end

        checks++;
        if (err !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL drain_entry err=%0b out_valid=%0b exp 0/1", err, out_valid); end
        if (in_pct >= 100) begin
            // cfg cycle + one cycle per word + issue + core wait + response cycle
            exp_lat = 1 + NUM_WORDS + 1 + (req_dly + rsp_dly) + 1;
            checks++;
            if (cyc - e_cfg + 1 != exp_lat) begin failures++; $display("FAIL latency got=%0d exp=%0d", cyc - e_cfg + 1, exp_lat); end
        end

        j = 0;
        guard = 0;
        bad = 0;
        stalled = 0;
        first_bad = -1;
        got_d = '0;
        while (j < nr && guard < 500) begin
            if (j == abort_row) begin mid_reset("rst_drain"); return; end
            out_ready = !(j == stall_row && stalled < stall_len);
            if (!out_ready) stalled++;
            if (out_valid !== 1'b1 || out_data !== r[j] || out_idx !== RCNT_W'(j) ||
                out_last !== (j == nr - 1) || cfg_ready !== 1'b0) begin
                bad++;
                if (first_bad < 0) begin first_bad = j; got_d = out_data; end
            end
            if (out_ready) j++;
            step();
            guard++;
        end
        out_ready = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL drain_rows bad=%0d first_row=%0d got=%h exp=%h", bad, first_bad, got_d, r[first_bad]); end
        checks++;
        if (j != nr) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", j, nr); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || err !== 1'b0)
            begin failures++; $display("FAIL drain_end out_valid=%0b busy=%0b cfg_ready=%0b err=%0b exp 0/0/1/0", out_valid, busy, cfg_ready, err); end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b0 || core_req_valid !== 1'b0 ||
            core_rsp_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0)
            begin failures++; $display("FAIL reset_state busy=%0b cfg_ready=%0b in_ready=%0b req_v=%0b rsp_r=%0b out_v=%0b err=%0b", busy, cfg_ready, in_ready, core_req_valid, core_rsp_ready, out_valid, err); end
        checks++;
        if (core_req !== '0) begin failures++; $display("FAIL reset_buf got_n=%0d exp cleared", core_req.n); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_job(5'd8, 16, 1'b1, 100, 0, 0, -1, 0, -1, -1);
    endtask

    task automatic test_bad_cfg();
        logic [N_W-1:0] bad_n [3];
        bad_n[0] = 5'd0;
        bad_n[1] = 5'd17;
        bad_n[2] = 5'($urandom_range(31, 18));
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_n     = bad_n[i];
            step();
            cfg_valid = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
                begin failures++; $display("FAIL bad_cfg n=%0d err=%0b busy=%0b in_ready=%0b exp 1/0/0", bad_n[i], err, busy, in_ready); end
            step();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
                begin failures++; $display("FAIL bad_cfg_pulse n=%0d err=%0b busy=%0b in_ready=%0b exp 0/0/0", bad_n[i], err, busy, in_ready); end
        end
    endtask

    task automatic test_input_gaps();
        run_job(5'd16, 32, 1'b0, 50, 5, 2, -1, 0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_job(5'($urandom_range(16, 1)), 8, 1'b0, 100, 0, 1, 2, 3, -1, -1);
    endtask

    task automatic test_bad_rows();
        run_job(5'd4, 0, 1'b0, 100, 0, 1, -1, 0, -1, -1);
        run_job(5'd4, 33, 1'b0, 100, 1, 0, -1, 0, -1, -1);
    endtask

    task automatic test_timeout();
        run_job(5'd5, 4, 1'b0, 100, 1, -1, -1, 0, -1, -1);
    endtask

    task automatic test_reset_midjob();
        run_job(5'd12, 10, 1'b0, 100, 0, 0, -1, 0, 10, -1);
        run_job(5'd12, 10, 1'b0, 100, 0, 0, -1, 0, -1, 4);
        run_job(5'd1, 2, 1'b0, 100, 0, 0, -1, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 10; t++) begin
            run_job(5'($urandom_range(16, 1)), $urandom_range(32, 1), 1'b0,
                    $urandom_range(100, 40), $urandom_range(4), $urandom_range(TMO - 2),
                    $urandom_range(8), $urandom_range(3), -1, -1);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_bad_cfg();
        test_input_gaps();
        test_backpressure();
        test_bad_rows();
        test_timeout();
        test_reset_midjob();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btu_sched.md
Name: btu_sched

Overview:
Sequencing controller for the bit-transpose unit (BTU) core. It accepts a job config (bit width n), then collects NUM_WORDS 32-bit words one per cycle into a staging buffer. It issues one btu_input_t request to the core, captures the btu_output_t response, and streams the num_rows valid output rows downstream one per cycle. It sits between the word-stream producer/consumer and the combinational-or-pipelined BTU core, and owns all handshaking, counting and error checks.

Parameters:
TIMEOUT_CYCLES, 1024, cycles allowed in WAIT before abort; 0 disables the watchdog.
(Word, row and n widths come from btu_pkg: DATA_WIDTH=32, NUM_WORDS=32, MAX_N=16, MAX_OUTPUT=32.)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  job start request
cfg_ready  out  1  controller can accept a job
cfg_n  in  5  bit width for the job, legal range 1..16
in_valid  in  1  input word valid
in_ready  out  1  input word accepted
in_data  in  32  input word
core_req_valid  out  1  request to core valid
core_req_ready  in  1  core accepts request
core_req  out  btu_input_t  {n, data[31:0]}
core_rsp_valid  in  1  core response valid
core_rsp_ready  out  1  controller accepts response
core_rsp  in  btu_output_t  {num_rows, rows}
out_valid  out  1  output row valid
out_ready  in  1  downstream accepts row
out_data  out  32  output row
out_idx  out  5  index of current row
out_last  out  1  final row of job
busy  out  1  state != IDLE
err  out  1  one-cycle error pulse

Behaviour:
- Single clock. Reset is synchronous and active-high. On reset: state=IDLE, all counters=0, the buffer and captured response are cleared, err=0.
- Handshakes are valid&&ready. Valid signals are driven only from state, never from the matching ready.
- IDLE: cfg_ready=1; all other valids/readies=0.
  - cfg handshake with cfg_n in 1..16: latch n, wcnt=0, go to LOAD.
  - cfg_n==0 or cfg_n>16: err=1 for one cycle next clock; stay in IDLE.
- LOAD: in_ready=1. Each handshake writes buf[wcnt]=in_data and increments wcnt.
  - The handshake at wcnt==31 moves to ISSUE.
  - Word k accepted maps to core_req.data[k]. No bubbles are required; 32 back-to-back words take 32 cycles.
- ISSUE: core_req_valid=1, core_req={n_latched, buf}, held stable until core_req_ready. On handshake go to WAIT and set wd=0.
- WAIT: core_rsp_ready=1. wd increments each cycle.
  - On core_rsp handshake, latch rows and num_rows.
  - If num_rows==0 or num_rows>32: err pulse, go to IDLE.
  - Otherwise go to DRAIN with rcnt=0.
  - If TIMEOUT_CYCLES!=0 and wd reaches TIMEOUT_CYCLES-1 without a response: err pulse, go to IDLE. A response arriving in that same cycle wins over the timeout.
- DRAIN: out_valid=1, out_data=rows[rcnt], out_idx=rcnt, out_last=(rcnt==num_rows-1).
  - Outputs are held stable under backpressure.
  - Each handshake increments rcnt. The handshake with out_last set returns to IDLE.
- cfg_ready=0 in every state except IDLE. A new job cannot overlap drain.
- Minimum job latency, cfg accept to first out_valid: 1 + 32 + 1 + core latency + 1 cycles.
- Reset mid-job, in any state: the job is discarded, nothing further is emitted, and the state is IDLE on the next cycle.
- All outputs are combinational decodes of registered state/counters/buffers. There is no combinational path from any input to any output, except data muxing from registered values.

Decomposition:
- Add to btu_pkg:
  - btu_sched_state_e enum: IDLE, LOAD, ISSUE, WAIT, DRAIN.
  - Constants MIN_N=1 and WCNT_W=$clog2(NUM_WORDS).
  - Helper function n_legal(n).
- Single module, no sub-module needed. The staging buffer is a plain register array in btu_sched.
- The BTU core is instantiated by the parent, not inside btu_sched.

Test Plan:
- Reset, then cfg_n=8, 32 words 0..31 back-to-back, core_req_ready=1, core model returns num_rows=16 -> core_req.data[k]==k and n==8; 16 rows out in order; out_idx 0..15; out_last only at idx 15; then cfg_ready=1.
- cfg_n=0 and cfg_n=17 -> err high exactly one cycle each; busy stays 0; in_ready stays 0.
- cfg_n=16, in_valid toggled randomly, core_req_ready delayed 5 cycles -> core_req held stable for all 5 cycles; exactly 32 words consumed; num_rows=32 gives 32 rows.
- DRAIN with out_ready low 3 cycles at row 2 -> out_data/out_idx frozen at row 2; no row lost or duplicated.
- TIMEOUT_CYCLES=8, no core response -> err pulse 8 cycles after entering WAIT; return to IDLE; no out_valid.
- reset asserted at wcnt=10 and again mid-DRAIN -> IDLE next cycle; a following job of n=1, num_rows=2 completes correctly.
